serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Registered sum, carry-out and signed overflow on completion.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] xr, yr, pr;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             s, cn, last, load;

  always_comb begin
    s    = xr[0] ^ yr[0] ^ c;
    cn   = (xr[0] & yr[0]) | (c & (xr[0] ^ yr[0]));
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right; each result bit enters at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr   <= '0;
      yr   <= '0;
      pr   <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      xr  <= a;
      yr  <= b;
      pr  <= '0;
      c   <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      xr  <= xr >> 1;
      yr  <= yr >> 1;
      pr  <= {s, pr[WIDTH-1:1]};
      c   <= cn;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum  <= {s, pr[WIDTH-1:1]};
        cout <= cn;
        ovf  <= c ^ cn;
      end
    end
  end

endmodule
